// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl_if
//  Description : Hazard/stall sequencer bundle. Carries the ID/EX hazard
//                operands, the MEM-stage data-memory handshake, the branch
//                resolution flag and the stall/flush controls returned to the
//                pipeline.
//                master : pipeline / memory side (drives hazard and handshake
//                         inputs, consumes stall and flush controls)
//                slave  : the stall controller
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stall_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 32
);
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic                  ex_is_load;
    logic                  ex_we;
    logic [REG_ADDR_W-1:0] ex_reg_waddr;
    logic                  mem_req;
    logic                  mem_ack;
    logic                  branch_taken;
    logic                  dm_req;
    logic [1:0]            stall;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic                  mem_err;
    logic [PERF_W-1:0]     perf_stall_cyc;

    modport master (
        output id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
        output ex_is_load, ex_we, ex_reg_waddr,
        output mem_req, mem_ack, branch_taken,
        input  dm_req, stall, flush_if_id, flush_id_ex, mem_err, perf_stall_cyc
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
        input  ex_is_load, ex_we, ex_reg_waddr,
        input  mem_req, mem_ack, branch_taken,
        output dm_req, stall, flush_if_id, flush_id_ex, mem_err, perf_stall_cyc
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : Central hazard/stall sequencer for the 5-stage pipeline.
//                Load-use bubbles, taken-branch flushes and the data-memory
//                wait-state handshake with timeout abort.
//                Optional feature macro: STALL_PERF_CNT_EN (stall-cycle
//                performance counter; tied to zero when undefined).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int PERF_W      = 32
) (
    input  wire              clk,
    input  wire              rst,     // synchronous, active-low
    pipe_stall_ctrl_if.slave bus
);

    localparam int                 c_CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_mem_err;

    logic w_mem_stall;
    logic w_hit;
    logic w_dm_req;

    // Memory wait-state sequencer; the abort pulse is registered on entry to ERR
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mem_err <= 1'b0;
                    if (bus.mem_req && !bus.mem_ack) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= c_CNT_ONE;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_ack) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state   <= ST_ERR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                ST_ERR: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_mem_err <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_mem_err <= 1'b0;
                end
            endcase
        end
    end

    // Memory request/stall decode: the access holds the pipe until the ack cycle
    always_comb begin
        w_mem_stall = 1'b0;
        w_dm_req    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_dm_req    = bus.mem_req;
                w_mem_stall = bus.mem_req & ~bus.mem_ack;
            end
            ST_WAIT: begin
                w_dm_req    = 1'b1;
                w_mem_stall = ~bus.mem_ack;
            end
            default: begin
                w_dm_req    = 1'b0;
                w_mem_stall = 1'b0;
            end
        endcase
    end

    // Load-use hazard: a load in EX targeting a register the ID instruction reads
    always_comb begin
        w_hit = bus.ex_is_load & bus.ex_we & (bus.ex_reg_waddr != '0) &
                ((bus.id_rs_used & (bus.id_rs_addr == bus.ex_reg_waddr)) |
                 (bus.id_rt_used & (bus.id_rt_addr == bus.ex_reg_waddr)));
    end

    // Priority merge: memory stall > branch flush > load-use bubble
    always_comb begin
        bus.stall[1]    = w_mem_stall;
        bus.stall[0]    = w_mem_stall | (w_hit & ~bus.branch_taken);
        bus.flush_if_id = ~w_mem_stall & bus.branch_taken;
        bus.flush_id_ex = ~w_mem_stall & (bus.branch_taken | w_hit);
        bus.dm_req      = w_dm_req;
        bus.mem_err     = r_mem_err;
    end

`ifdef STALL_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf;

    // Saturating count of every cycle in which any stage is held
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf <= '0;
        end else if ((w_mem_stall | (w_hit & ~bus.branch_taken)) && (r_perf != {PERF_W{1'b1}})) begin
            r_perf <= r_perf + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.perf_stall_cyc = r_perf;
`else
    assign bus.perf_stall_cyc = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stall_ctrl
//  Description : Directed self-checking bench for pipe_stall_ctrl. Outputs are
//                packed as {stall[1:0], flush_if_id, flush_id_ex, dm_req,
//                mem_err} and compared at the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int REG_ADDR_W  = 5;
    localparam int MEM_TIMEOUT = 16;
    localparam int PERF_W      = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic running;

    pipe_stall_ctrl_if #(.REG_ADDR_W(REG_ADDR_W), .PERF_W(PERF_W)) bus ();

    pipe_stall_ctrl #(
        .REG_ADDR_W (REG_ADDR_W),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .PERF_W     (PERF_W)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [5:0] obs = {bus.stall, bus.flush_if_id, bus.flush_id_ex, bus.dm_req, bus.mem_err};

    // Packed expectations
    localparam logic [5:0] E_IDLE = 6'b00_0_0_0_0;
    localparam logic [5:0] E_LU   = 6'b01_0_1_0_0;
    localparam logic [5:0] E_MEMW = 6'b11_0_0_1_0;
    localparam logic [5:0] E_ACK  = 6'b00_0_0_1_0;
    localparam logic [5:0] E_ERR  = 6'b00_0_0_0_1;
    localparam logic [5:0] E_BR   = 6'b00_1_1_0_0;
    localparam logic [5:0] E_BRAK = 6'b00_1_1_1_0;

    // The held-EX-only encoding must never appear
    always @(negedge clk) begin
        if (running && rst) begin
            checks++;
            if (bus.stall === 2'b10) begin
                errors++;
                $display("FAIL stall_invariant: stall=%b required not 10", bus.stall);
            end
        end
    end

    task automatic clear_inputs();
        bus.id_rs_addr   = '0;
        bus.id_rt_addr   = '0;
        bus.id_rs_used   = 1'b0;
        bus.id_rt_used   = 1'b0;
        bus.ex_is_load   = 1'b0;
        bus.ex_we        = 1'b0;
        bus.ex_reg_waddr = '0;
        bus.mem_req      = 1'b0;
        bus.mem_ack      = 1'b0;
        bus.branch_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] waddr, input logic [4:0] rs, input logic rs_used,
                                input logic [4:0] rt, input logic rt_used, input logic we);
        bus.ex_is_load   = 1'b1;
        bus.ex_we        = we;
        bus.ex_reg_waddr = waddr;
        bus.id_rs_addr   = rs;
        bus.id_rs_used   = rs_used;
        bus.id_rt_addr   = rt;
        bus.id_rt_used   = rt_used;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (obs !== E_IDLE) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs, E_IDLE);
        end
        checks++;
        if (bus.perf_stall_cyc !== '0) begin
            errors++;
            $display("FAIL reset_perf: got %0d expected 0", bus.perf_stall_cyc);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_mem_wait();
        logic [5:0] exp_seq [4] = '{E_MEMW, E_MEMW, E_MEMW, E_ACK};
        clear_inputs();
        bus.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ack = (i == 3);
            @(negedge clk);
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL mem_wait_cyc%0d: got %b expected %b", i, obs, exp_seq[i]);
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (obs !== E_IDLE) begin
            errors++;
            $display("FAIL mem_wait_back_idle: got %b expected %b", obs, E_IDLE);
        end
        tick();
        // Zero-wait access: request and ack together never stall
        bus.mem_req = 1'b1;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_ACK) begin
            errors++;
            $display("FAIL mem_zero_wait: got %b expected %b", obs, E_ACK);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (obs !== E_IDLE) begin
            errors++;
            $display("FAIL mem_zero_wait_after: got %b expected %b", obs, E_IDLE);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [PERF_W-1:0] exp_perf;
`ifdef STALL_PERF_CNT_EN
        exp_perf = 32'd4;
`else
        exp_perf = 32'd0;
`endif
        clear_inputs();
        set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (obs !== E_LU) begin
            errors++;
            $display("FAIL load_use_rs: got %b expected %b", obs, E_LU);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (obs !== E_IDLE) begin
            errors++;
            $display("FAIL load_use_one_cycle: got %b expected %b", obs, E_IDLE);
        end
        checks++;
        if (bus.perf_stall_cyc !== exp_perf) begin
            errors++;
            $display("FAIL perf_after_wait_and_lu: got %0d expected %0d", bus.perf_stall_cyc, exp_perf);
        end
        tick();
        // r0 destination never creates a hazard
        set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (obs !== E_IDLE) begin
            errors++;
            $display("FAIL load_use_r0: got %b expected %b", obs, E_IDLE);
        end
        tick();
        set_load_use(5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (obs !== E_LU) begin
            errors++;
            $display("FAIL load_use_rt: got %b expected %b", obs, E_LU);
        end
        tick();
        set_load_use(5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (obs !== E_IDLE) begin
            errors++;
            $display("FAIL load_use_rt_unused: got %b expected %b", obs, E_IDLE);
        end
        tick();
        set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (obs !== E_IDLE) begin
            errors++;
            $display("FAIL load_use_no_we: got %b expected %b", obs, E_IDLE);
        end
        tick();
        set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1);
        bus.ex_is_load = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== E_IDLE) begin
            errors++;
            $display("FAIL load_use_not_load: got %b expected %b", obs, E_IDLE);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        clear_inputs();
        bus.mem_req = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== E_MEMW) begin
                errors++;
                $display("FAIL timeout_wait_cyc%0d: got %b expected %b", i, obs, E_MEMW);
            end
            tick();
        end
        bus.mem_req = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== E_ERR) begin
            errors++;
            $display("FAIL timeout_err: got %b expected %b", obs, E_ERR);
        end
        tick();
        @(negedge clk);
        checks++;
        if (obs !== E_IDLE) begin
            errors++;
            $display("FAIL timeout_back_idle: got %b expected %b", obs, E_IDLE);
        end
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        set_load_use(5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1);
        bus.branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_BR) begin
            errors++;
            $display("FAIL branch_over_load_use: got %b expected %b", obs, E_BR);
        end
        tick();
        clear_inputs();
        bus.branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_BR) begin
            errors++;
            $display("FAIL branch_alone: got %b expected %b", obs, E_BR);
        end
        tick();
        // Branch and load-use during a memory wait are both suppressed
        bus.mem_req = 1'b1;
        set_load_use(5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== E_MEMW) begin
                errors++;
                $display("FAIL branch_in_wait_cyc%0d: got %b expected %b", i, obs, E_MEMW);
            end
            tick();
        end
        bus.ex_is_load = 1'b0;
        bus.mem_ack    = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_BRAK) begin
            errors++;
            $display("FAIL branch_at_ack: got %b expected %b", obs, E_BRAK);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs();
        bus.mem_req = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (obs !== E_MEMW) begin
            errors++;
            $display("FAIL midrst_in_wait: got %b expected %b", obs, E_MEMW);
        end
        rst = 1'b0;
        tick();
        bus.mem_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== E_IDLE) begin
            errors++;
            $display("FAIL midrst_idle: got %b expected %b", obs, E_IDLE);
        end
        checks++;
        if (bus.perf_stall_cyc !== '0) begin
            errors++;
            $display("FAIL midrst_perf: got %0d expected 0", bus.perf_stall_cyc);
        end
        tick();
        // Fresh access after reset waits with a cleared counter, then completes
        bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ack = (i == 2);
            @(negedge clk);
            checks++;
            if (obs !== ((i == 2) ? E_ACK : E_MEMW)) begin
                errors++;
                $display("FAIL midrst_reaccess_cyc%0d: got %b expected %b", i, obs,
                         (i == 2) ? E_ACK : E_MEMW);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        running = 1'b0;
        rst     = 1'b0;
        clear_inputs();
        test_reset();
        running = 1'b1;
        test_mem_wait();
        test_load_use();
        test_timeout();
        test_branch();
        test_reset_mid_wait();
        running = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
